// File: rtl/reg_pkg.sv
// Shared types for the register bank: write operation codes.
package reg_pkg;

  localparam int REG_OP_W = 3;

  typedef enum logic [REG_OP_W-1:0] {
    OP_LOAD = 3'd0,
    OP_CLR  = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_ROL  = 3'd6,
    OP_ROR  = 3'd7
  } reg_op_t;

endpackage

// File: rtl/reg_op_unit.sv
// Combinational in-place operation on one entry: result r and carry/borrow/shift-out c.
module reg_op_unit
  import reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  reg_op_t          op,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] r,
  output logic             c
);

  // Extra top bit captures carry-out on increment and borrow on decrement.
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;

  assign inc_ext = {1'b0, v} + (WIDTH+1)'(1);
  assign dec_ext = {1'b0, v} - (WIDTH+1)'(1);

  always_comb begin
    r = '0;
    c = 1'b0;
    case (op)
      OP_LOAD: r = wdata;
      OP_CLR:  r = '0;
      OP_INC:  {c, r} = inc_ext;
      OP_DEC:  {c, r} = dec_ext;
      OP_SHL:  begin r = {v[WIDTH-2:0], 1'b0};     c = v[WIDTH-1]; end
      OP_SHR:  begin r = {1'b0, v[WIDTH-1:1]};     c = v[0];       end
      OP_ROL:  begin r = {v[WIDTH-2:0], v[WIDTH-1]}; c = v[WIDTH-1]; end
      OP_ROR:  begin r = {v[0], v[WIDTH-1:1]};     c = v[0];       end
      default: begin r = '0; c = 1'b0; end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank with one op-applying write port, one registered
// read port (no forwarding) and carry/zero flags from the last accepted write.
module reg_bank
  import reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  reg_op_t          op,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             carry,
  output logic             zero
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wok;
  logic                        rok;
  logic [WIDTH-1:0]            v;
  logic [WIDTH-1:0]            r;
  logic                        c;

  // When DEPTH fills the address space every address is in range.
  if (DEPTH == (1 << AW)) begin : g_full
    assign wok = 1'b1;
    assign rok = 1'b1;
  end else begin : g_part
    assign wok = (waddr < AW'(DEPTH));
    assign rok = (raddr < AW'(DEPTH));
  end

  assign v = wok ? mem[waddr] : '0;

  reg_op_unit #(.WIDTH(WIDTH)) u_op (
    .op    (op),
    .v     (v),
    .wdata (wdata),
    .r     (r),
    .c     (c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      rdata <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      // Read samples the pre-write contents; same-address writes show up a cycle later.
      rdata <= rok ? mem[raddr] : '0;
      if (we && wok) begin
        mem[waddr] <= r;
        carry      <= c;
        zero       <= (r == '0);
      end
    end
  end

endmodule
